mem_arbiter: RTL

- Memory-side responder for the cache/control protocol.
- Accepts word requests from one dcache port and one icache port and arbitrates them onto the single RAM port.
- Returns load data and wait/handshake to the requesting cache.
- Sits between the caches and the RAM model. It is the other end of the handshake the caches initiate.

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the cache/RAM side of the CPU: the data word, the RAM
// handshake state, the memory arbiter's grant states and the word returned
// to a cache when a RAM transaction fails or times out.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // RAM handshake as reported by the RAM model each cycle
   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   // Registered grant of the memory arbiter
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DGNT = 2'b01,
      IGNT = 2'b10
   } arb_state_t;

   // Load value handed back on a RAM error or a timed-out grant
   localparam word_t BADWORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Memory-side responder for the dcache and icache. Arbitrates word requests
// from both caches onto the single RAM port and returns load data plus the
// wait handshake to whichever cache holds the grant.
//
// Ports:
//   CLK, RST             clock (rising edge), synchronous active-high reset
//   dREN, dWEN           dcache read / write request
//   daddr, dstore        dcache word address and write data
//   dwait, dload         dcache busy flag and read data
//   iREN, iaddr          icache read request and word address
//   iwait, iload         icache busy flag and read data
//   ramREN, ramWEN       RAM read / write strobes
//   ramaddr, ramstore    RAM address and write data
//   ramload, ramstate    RAM read data and handshake state
//   bus_err              sticky flag, set by a RAM error or a timeout
//
// Parameters:
//   STARVE_MAX  consecutive dcache wins allowed while icache waits
//   TIMEOUT     grant cycles allowed before a forced error completion
// ---------------------------------------------------------------------------
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        bus_err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   arb_state_t    state;
   arb_state_t    next_state;
   logic [SW-1:0] starve_cnt;
   logic [SW-1:0] next_starve;
   logic [TW-1:0] tmo_cnt;
   logic          dreq;
   logic          greq;
   logic          done;
   logic          fail;

   // Completion qualifiers for the current grant. A dropped request is an
   // abort and takes priority over anything the RAM reports, so an aborted
   // grant never produces a completion pulse.
   always_comb begin
      dreq = dREN | dWEN;
      greq = 1'b0;
      case (state)
         DGNT:    greq = dreq;
         IGNT:    greq = iREN;
         default: greq = 1'b0;
      endcase
      fail = greq && ((ramstate == ERROR) || (tmo_cnt == TW'(TIMEOUT)));
      done = greq && ((ramstate == ACCESS) || fail);
   end

   // Arbitration and grant release. The dcache normally wins a tie, but once
   // it has won STARVE_MAX times in a row against a waiting icache, the
   // icache is forced through. Every grant returns to IDLE, which gives the
   // bubble cycle that keeps a stale request from being served twice.
   always_comb begin
      next_state  = state;
      next_starve = starve_cnt;
      case (state)
         IDLE: begin
            if (dreq && iREN) begin
               if (starve_cnt == SW'(STARVE_MAX)) begin
                  next_state  = IGNT;
                  next_starve = '0;
               end else begin
                  next_state  = DGNT;
                  next_starve = starve_cnt + 1'b1;
               end
            end else if (dreq) begin
               next_state  = DGNT;
               next_starve = '0;
            end else if (iREN) begin
               next_state  = IGNT;
               next_starve = '0;
            end else begin
               next_starve = '0;
            end
         end
         DGNT, IGNT: begin
            if (!greq || done) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Registered grant, starvation counter, timeout counter and sticky error.
   // The timeout counter only runs while a grant is held across cycles and
   // is cleared whenever the arbiter goes back to IDLE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         bus_err    <= 1'b0;
      end else begin
         state      <= next_state;
         starve_cnt <= next_starve;
         if ((state != IDLE) && (next_state != IDLE)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end
         if (fail) begin
            bus_err <= 1'b1;
         end
      end
   end

   // RAM port and cache responses. RAM signals follow the granted cache's
   // live inputs combinationally; the non-granted cache always sees wait=1
   // and load=0. Everything is forced quiet while reset is asserted, since
   // the registered state may still hold an old grant in that cycle.
   always_comb begin
      dwait    = 1'b1;
      iwait    = 1'b1;
      dload    = '0;
      iload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (!RST) begin
         case (state)
            DGNT: begin
               if (dreq) begin
                  ramaddr  = daddr;
                  ramWEN   = dWEN;
                  ramREN   = dREN & ~dWEN;
                  ramstore = dWEN ? dstore : '0;
               end
               if (done) begin
                  dwait = 1'b0;
                  dload = fail ? BADWORD : (dWEN ? '0 : ramload);
               end
            end
            IGNT: begin
               if (iREN) begin
                  ramREN  = 1'b1;
                  ramaddr = iaddr;
               end
               if (done) begin
                  iwait = 1'b0;
                  iload = fail ? BADWORD : ramload;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
